hex_text_entry: RTL and testbench

HEX_TEXT_ENTRY -- requirements
Module: hex_text_entry

---
 rtl/hex_text_entry.sv | 137 +++++++++++++
 tb/tb_hex_text_entry.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_text_entry.sv
// Hex text entry: assembles typed hex characters into a right-aligned word,
// supports backspace/escape editing, and commits the word on Enter through a
// valid/ready handshake towards the consumer.
module hex_text_entry #(
    parameter int NDIG = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [6:0]                    char_in,
    input  logic                          char_valid,
    output logic                          char_ready,
    output logic [4*NDIG-1:0]             entry_value,
    output logic [$clog2(NDIG+1)-1:0]     digit_count,
    output logic [4*NDIG-1:0]             data,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          entry_err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(NDIG);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        value_nxt;
    logic [CW-1:0]       count_nxt;
    logic [W-1:0]        data_nxt;
    logic                valid_nxt;
    logic                err_nxt;

    logic                is_digit, is_bs, is_enter, is_esc;
    logic [3:0]          nibble;
    logic                accept;

    // Characters are only taken while no committed word is waiting
    assign char_ready = (state != HOLD);
    assign accept     = char_valid && char_ready;

    // Classify the incoming ASCII code and extract its hex nibble
    always_comb begin
        is_digit = 1'b0;
        is_bs    = (char_in == 7'h08);
        is_enter = (char_in == 7'h0D);
        is_esc   = (char_in == 7'h1B);
        nibble   = 4'h0;
        if (char_in >= 7'h30 && char_in <= 7'h39) begin
            is_digit = 1'b1;
            nibble   = char_in[3:0];
        end else if ((char_in >= 7'h41 && char_in <= 7'h46) ||
                     (char_in >= 7'h61 && char_in <= 7'h66)) begin
            is_digit = 1'b1;
            nibble   = char_in[3:0] + 4'd9;
        end
    end

    // Next-state and next-register logic for the entry state machine
    always_comb begin
        state_nxt = state;
        value_nxt = entry_value;
        count_nxt = digit_count;
        data_nxt  = data;
        valid_nxt = data_valid;
        err_nxt   = 1'b0;
        case (state)
            HOLD: begin
                if (data_ready) begin
                    valid_nxt = 1'b0;
                    value_nxt = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                if (accept) begin
                    if (is_digit) begin
                        if (digit_count < MAX_COUNT) begin
                            value_nxt = {entry_value[W-5:0], nibble};
                            count_nxt = digit_count + ONE;
                            state_nxt = ENTRY;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (is_bs) begin
                        if (digit_count != '0) begin
                            value_nxt = entry_value >> 4;
                            count_nxt = digit_count - ONE;
                            state_nxt = (digit_count == ONE) ? IDLE : ENTRY;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (is_enter) begin
                        if (digit_count != '0) begin
                            data_nxt  = entry_value;
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (is_esc) begin
                        value_nxt = '0;
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            entry_value <= '0;
            digit_count <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_value <= value_nxt;
            digit_count <= count_nxt;
            data        <= data_nxt;
            data_valid  <= valid_nxt;
            entry_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_hex_text_entry.sv
// Bench for hex_text_entry: directed scenarios followed by random typing,
// all compared against a digit-queue reference model.
module tb_hex_text_entry;

    logic        clk;
    logic        reset_n;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        entry_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: typed digits kept as a queue of nibbles
    logic [3:0]  m_digits[$];
    logic        m_hold;
    logic [31:0] m_data;
    logic        m_err;

    hex_text_entry #(.NDIG(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .entry_err   (entry_err)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_value();
        logic [31:0] v = 0;
        foreach (m_digits[i]) v = v * 16 + 32'(m_digits[i]);
        return v;
    endfunction

    function automatic int hex_of(input logic [6:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, " value"}, entry_value, model_value());
        check_output({tag, " count"}, 32'(digit_count), 32'(m_digits.size()));
        check_output({tag, " data"}, data, m_data);
        check_output({tag, " dvalid"}, 32'(data_valid), 32'(m_hold));
        check_output({tag, " err"}, 32'(entry_err), 32'(m_err));
        check_output({tag, " cready"}, 32'(char_ready), 32'(!m_hold));
    endtask

    // Advance the model by one clock edge using the spec's editing rules
    task automatic model_edge(input logic [6:0] c, input logic v, input logic r);
        int h;
        m_err = 1'b0;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                m_digits.delete();
            end
        end else if (v) begin
            h = hex_of(c);
            if (h >= 0) begin
                if (m_digits.size() < 8) m_digits.push_back(4'(h));
                else m_err = 1'b1;
            end else if (c == 7'h08) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
                else m_err = 1'b1;
            end else if (c == 7'h0D) begin
                if (m_digits.size() > 0) begin
                    m_data = model_value();
                    m_hold = 1'b1;
                end else m_err = 1'b1;
            end else if (c == 7'h1B) begin
                m_digits.delete();
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [6:0] c, input logic v, input logic r, input string tag);
        @(negedge clk);
        char_in    = c;
        char_valid = v;
        data_ready = r;
        #1;
        check_output({tag, " pre-ready"}, 32'(char_ready), 32'(!m_hold));
        @(posedge clk);
        model_edge(c, v, r);
        #1;
        check_all(tag);
    endtask

    task automatic type_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) apply_stimulus(7'(s[i]), 1'b1, 1'b0, tag);
    endtask

    // Assert reset between edges, confirm the immediate clear, release before the next edge
    task automatic mid_reset(input string tag);
        @(negedge clk);
        char_valid = 1'b0;
        data_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        m_digits.delete();
        m_hold = 1'b0;
        m_data = 0;
        m_err  = 1'b0;
        check_all(tag);
        @(posedge clk);
        #1 check_all({tag, " held"});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        string hexchars = "0123456789abcdefABCDEF";
        logic [6:0] c;
        logic v, r;
        int sel;

        reset_n    = 1'b0;
        char_in    = 7'h00;
        char_valid = 1'b0;
        data_ready = 1'b0;
        m_hold     = 1'b0;
        m_data     = 0;
        m_err      = 1'b0;
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // "1a2B" then Enter
        type_str("1a2B", "t034");
        check_output("t034 value const", entry_value, 32'h00001A2B);
        apply_stimulus(7'h0D, 1'b1, 1'b0, "t034 enter");
        check_output("t034 data const", data, 32'h00001A2B);
        apply_stimulus(7'h00, 1'b0, 1'b1, "t034 ack");

        // Nine digits: the ninth overflows
        type_str("12345678", "t035");
        check_output("t035 value const", entry_value, 32'h12345678);
        apply_stimulus("9", 1'b1, 1'b0, "t035 ninth");
        check_output("t035 err const", 32'(entry_err), 32'd1);
        apply_stimulus(7'h00, 1'b0, 1'b0, "t035 err gone");
        apply_stimulus(7'h1B, 1'b1, 1'b0, "t035 esc");

        // Backspace editing
        type_str("ABC", "t036");
        apply_stimulus(7'h08, 1'b1, 1'b0, "t036 bs");
        check_output("t036 bs const", entry_value, 32'h00000AB);
        apply_stimulus("D", 1'b1, 1'b0, "t036 D");
        check_output("t036 D const", entry_value, 32'h00000ABD);
        apply_stimulus(7'h1B, 1'b1, 1'b0, "t036 esc");

        // HOLD drops characters until acknowledged
        type_str("CAFE", "t037");
        apply_stimulus(7'h0D, 1'b1, 1'b0, "t037 enter");
        for (int i = 0; i < 3; i++) apply_stimulus("5", 1'b1, 1'b0, "t037 hold");
        apply_stimulus("5", 1'b1, 1'b1, "t037 ack");
        check_output("t037 data const", data, 32'h0000CAFE);

        // Error cases and escape
        apply_stimulus(7'h0D, 1'b1, 1'b0, "t038 enter0");
        apply_stimulus(7'h08, 1'b1, 1'b0, "t038 bs0");
        apply_stimulus(7'h47, 1'b1, 1'b0, "t038 G");
        apply_stimulus(7'h00, 1'b0, 1'b1, "t038 idle ack");
        type_str("FF", "t038");
        apply_stimulus(7'h1B, 1'b1, 1'b0, "t038 esc");

        // Reset mid-entry then fresh entry
        type_str("77", "t039");
        mid_reset("t039 reset");
        apply_stimulus("1", 1'b1, 1'b0, "t039 one");
        apply_stimulus(7'h0D, 1'b1, 1'b0, "t039 enter");
        check_output("t039 data const", data, 32'h00000001);
        apply_stimulus(7'h00, 1'b0, 1'b1, "t039 ack");

        // Random typing against the model
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 6)      c = 7'(hexchars[$urandom_range(0, 21)]);
            else if (sel == 7) c = 7'h08;
            else if (sel == 8) c = 7'h0D;
            else if (sel == 9) c = 7'h1B;
            else               c = 7'($urandom_range(0, 127));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) mid_reset("rand reset");
            else apply_stimulus(c, v, r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
